// File: rtl/sampler_scheduler_pkg.sv
// sampler_scheduler_pkg: constants and helpers shared by the sampler scheduler files.
// Holds the sweep FSM encoding, trigger thresholds in millivolts and the voice count.
package sampler_scheduler_pkg;

    localparam int NUM_VOICES    = 4;
    localparam int TRIGGER_HI_MV = 1000;
    localparam int TRIGGER_LO_MV = 500;

    // Sweep FSM encoding, kept as plain constants so older code can share it.
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_READ0   = 3'd1;
    localparam state_t ST_READ1   = 3'd2;
    localparam state_t ST_READ2   = 3'd3;
    localparam state_t ST_READ3   = 3'd4;
    localparam state_t ST_CAPTURE = 3'd5;

    // Convert a millivolt threshold into sample units (fixed-point shift).
    function automatic int mv_to_sample(input int mv, input int fp_offset);
        return mv <<< fp_offset;
    endfunction

endpackage

// File: rtl/sampler_scheduler_trigger_detect.sv
// sampler_trigger_detect: per-voice hysteresis comparator with a rising-edge pulse.
// The level only moves when eval is high (an accepted audio sample strobe); rise is
// a same-cycle pulse so the scheduler can restart the voice on that strobe edge.
module sampler_trigger_detect #(
    parameter int W         = 16,
    parameter int FP_OFFSET = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                eval,
    input  logic signed [W-1:0] sample_in,
    output logic                rise
);
    import sampler_scheduler_pkg::*;

    localparam logic signed [W-1:0] HI_THRESH = W'(mv_to_sample(TRIGGER_HI_MV, FP_OFFSET));
    localparam logic signed [W-1:0] LO_THRESH = W'(mv_to_sample(TRIGGER_LO_MV, FP_OFFSET));

    logic level_r;
    logic level_s;

    // Hysteresis: high at/above the upper threshold, low below the lower one, else hold.
    always_comb begin
        if (sample_in >= HI_THRESH) begin
            level_s = 1'b1;
        end else if (sample_in < LO_THRESH) begin
            level_s = 1'b0;
        end else begin
            level_s = level_r;
        end
    end

    assign rise = eval & ~level_r & level_s;

    // Level register, updated only on accepted strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_r <= 1'b0;
        end else if (eval) begin
            level_r <= level_s;
        end else begin
            level_r <= level_r;
        end
    end

endmodule

// File: rtl/sampler_scheduler.sv
// sampler_scheduler: four-voice one-shot sample player sharing a single ROM port.
// Each accepted strobe runs a sweep READ0..READ3 -> CAPTURE reading one word per
// active voice, then updates all four outputs at once with an out_valid pulse.
// Optional feature macro: SAMPLER_SCHEDULER_RETRIGGER_EN (trigger edges restart
// voices that are still playing; when undefined only idle voices can start).
module sampler_scheduler #(
    parameter int W          = 16,
    parameter int FP_OFFSET  = 2,
    parameter int SLOT_LEN   = 2048,
    parameter int SAMPLE_LEN = 1680,
    parameter int RATE_DIV   = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              sample_strobe,
    input  logic signed [W-1:0]               sample_in0,
    input  logic signed [W-1:0]               sample_in1,
    input  logic signed [W-1:0]               sample_in2,
    input  logic signed [W-1:0]               sample_in3,
    output logic [$clog2(4*SLOT_LEN)-1:0]     rom_addr,
    output logic                              rom_rd_en,
    input  logic signed [W-1:0]               rom_rdata,
    output logic signed [W-1:0]               sample_out0,
    output logic signed [W-1:0]               sample_out1,
    output logic signed [W-1:0]               sample_out2,
    output logic signed [W-1:0]               sample_out3,
    output logic                              out_valid,
    output logic                              overrun
);
    import sampler_scheduler_pkg::*;

    localparam int AW = $clog2(4*SLOT_LEN);
    localparam int SW = $clog2(SLOT_LEN);
    localparam int PW = $clog2(SAMPLE_LEN+1);
    localparam int DW = $clog2(RATE_DIV+1);
    localparam logic [PW-1:0] POS_END  = PW'(SAMPLE_LEN);
    localparam logic [DW-1:0] DIV_LAST = DW'(RATE_DIV-1);

`ifdef SAMPLER_SCHEDULER_RETRIGGER_EN
    localparam logic RETRIGGER_EN = 1'b1;
`else
    localparam logic RETRIGGER_EN = 1'b0;
`endif

    state_t                  state_r;
    state_t                  state_s;
    logic [PW-1:0]           pos_r [NUM_VOICES];
    logic [PW-1:0]           pos_s [NUM_VOICES];
    logic [NUM_VOICES-1:0]   restart_r;
    logic [NUM_VOICES-1:0]   restart_s;
    logic [NUM_VOICES-1:0]   rise_s;
    logic [DW-1:0]           div_r;
    logic                    adv_r;
    logic                    accept_s;
    logic                    rd_sel_s;
    logic [1:0]              rd_voice_s;
    logic                    rd_en_s;
    logic [AW-1:0]           addr_s;
    logic                    rd_pend_r;
    logic signed [W-1:0]     cap_data_s;
    logic signed [W-1:0]     voice_r [3];
    logic signed [W-1:0]     trig_in_s [NUM_VOICES];

    assign accept_s     = sample_strobe && (state_r == ST_IDLE);
    assign trig_in_s[0] = sample_in0;
    assign trig_in_s[1] = sample_in1;
    assign trig_in_s[2] = sample_in2;
    assign trig_in_s[3] = sample_in3;
    // Word arriving this cycle belongs to the voice read last cycle; idle voices read as 0.
    assign cap_data_s   = rd_pend_r ? rom_rdata : '0;

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_trig
        sampler_trigger_detect #(
            .W         (W),
            .FP_OFFSET (FP_OFFSET)
        ) u_trig (
            .clk       (clk),
            .rst       (rst),
            .eval      (accept_s),
            .sample_in (trig_in_s[g]),
            .rise      (rise_s[g])
        );
    end

    // Sweep sequencing: one strobe starts a fixed six-cycle walk through the voices.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (sample_strobe) begin
                    state_s = ST_READ0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ0:   state_s = ST_READ1;
            ST_READ1:   state_s = ST_READ2;
            ST_READ2:   state_s = ST_READ3;
            ST_READ3:   state_s = ST_CAPTURE;
            ST_CAPTURE: state_s = ST_IDLE;
            default:    state_s = ST_IDLE;
        endcase
    end

    // Playback positions: restart on a qualifying edge, advance in CAPTURE, saturate at end.
    always_comb begin
        for (int v = 0; v < NUM_VOICES; v++) begin
            pos_s[v]     = pos_r[v];
            restart_s[v] = restart_r[v];
            if (accept_s) begin
                restart_s[v] = rise_s[v] & (RETRIGGER_EN | (pos_r[v] >= POS_END));
                if (restart_s[v]) begin
                    pos_s[v] = '0;
                end else begin
                    pos_s[v] = pos_r[v];
                end
            end else if ((state_r == ST_CAPTURE) && adv_r && !restart_r[v] && (pos_r[v] < POS_END)) begin
                pos_s[v] = pos_r[v] + PW'(1'b1);
            end else begin
                pos_s[v] = pos_r[v];
            end
        end
    end

    // ROM request for the READ state being entered, so the port outputs are registered.
    always_comb begin
        rd_sel_s   = 1'b1;
        rd_voice_s = 2'd0;
        case (state_s)
            ST_READ0: rd_voice_s = 2'd0;
            ST_READ1: rd_voice_s = 2'd1;
            ST_READ2: rd_voice_s = 2'd2;
            ST_READ3: rd_voice_s = 2'd3;
            default:  rd_sel_s   = 1'b0;
        endcase
        if (rd_sel_s && (pos_s[rd_voice_s] < POS_END)) begin
            rd_en_s = 1'b1;
            addr_s  = (AW'(rd_voice_s) << SW) | AW'(pos_s[rd_voice_s]);
        end else begin
            rd_en_s = 1'b0;
            addr_s  = '0;
        end
    end

    // Control state: FSM, positions, restart flags, rate divider and sticky overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            for (int v = 0; v < NUM_VOICES; v++) begin
                pos_r[v] <= POS_END;
            end
            restart_r <= '0;
            div_r     <= '0;
            adv_r     <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state_r   <= state_s;
            for (int v = 0; v < NUM_VOICES; v++) begin
                pos_r[v] <= pos_s[v];
            end
            restart_r <= restart_s;
            if (accept_s) begin
                adv_r <= (div_r == DIV_LAST);
                div_r <= (div_r == DIV_LAST) ? '0 : div_r + DW'(1'b1);
            end
            if (sample_strobe && (state_r != ST_IDLE)) begin
                overrun <= 1'b1;
            end
        end
    end

    // ROM port registers plus the one-cycle read-data tracking flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_rd_en <= 1'b0;
            rom_addr  <= '0;
            rd_pend_r <= 1'b0;
        end else begin
            rom_rd_en <= rd_en_s;
            rom_addr  <= addr_s;
            rd_pend_r <= rom_rd_en;
        end
    end

    // Voice capture and simultaneous output update at the end of the sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            voice_r[0]  <= '0;
            voice_r[1]  <= '0;
            voice_r[2]  <= '0;
            sample_out0 <= '0;
            sample_out1 <= '0;
            sample_out2 <= '0;
            sample_out3 <= '0;
            out_valid   <= 1'b0;
        end else begin
            if (state_r == ST_READ1) begin
                voice_r[0] <= cap_data_s;
            end else if (state_r == ST_READ2) begin
                voice_r[1] <= cap_data_s;
            end else if (state_r == ST_READ3) begin
                voice_r[2] <= cap_data_s;
            end
            if (state_r == ST_CAPTURE) begin
                sample_out0 <= voice_r[0];
                sample_out1 <= voice_r[1];
                sample_out2 <= voice_r[2];
                sample_out3 <= cap_data_s;
            end
            out_valid <= (state_r == ST_CAPTURE);
        end
    end

endmodule

// File: tb/tb_sampler_scheduler.sv
// tb_sampler_scheduler: directed and randomized sweeps against a transaction-level
// model of voice start/advance/end rules, with a behavioural one-cycle-latency ROM.
module tb_sampler_scheduler;

    localparam int W          = 16;
    localparam int SLOT_LEN   = 2048;
    localparam int SAMPLE_LEN = 1680;
    localparam int RATE_DIV   = 2;
    localparam int AW         = 13;
    localparam int HI         = 4000;
    localparam int LO         = 2000;

`ifdef SAMPLER_SCHEDULER_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic                clk;
    logic                rst;
    logic                sample_strobe;
    logic signed [W-1:0] sample_in0, sample_in1, sample_in2, sample_in3;
    logic [AW-1:0]       rom_addr;
    logic                rom_rd_en;
    logic signed [W-1:0] rom_rdata;
    logic signed [W-1:0] sample_out0, sample_out1, sample_out2, sample_out3;
    logic                out_valid;
    logic                overrun;

    int checks   = 0;
    int failures = 0;

    // Transaction-level model state
    int m_pos [4];
    bit m_lvl [4];
    int m_div;

    sampler_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .sample_strobe (sample_strobe),
        .sample_in0    (sample_in0),
        .sample_in1    (sample_in1),
        .sample_in2    (sample_in2),
        .sample_in3    (sample_in3),
        .rom_addr      (rom_addr),
        .rom_rd_en     (rom_rd_en),
        .rom_rdata     (rom_rdata),
        .sample_out0   (sample_out0),
        .sample_out1   (sample_out1),
        .sample_out2   (sample_out2),
        .sample_out3   (sample_out3),
        .out_valid     (out_valid),
        .overrun       (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic signed [W-1:0] rom_word(input int a);
        return W'(a * 40503 + 12345);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock; the ROM answers a request from the previous cycle, else returns junk.
    task automatic tick();
        logic          p_en;
        logic [AW-1:0] p_a;
        p_en = rom_rd_en;
        p_a  = rom_addr;
        @(posedge clk);
        #1;
        if (p_en === 1'b1) rom_rdata = rom_word(int'(p_a));
        else               rom_rdata = W'($urandom);
    endtask

    task automatic model_reset();
        for (int v = 0; v < 4; v++) begin
            m_pos[v] = SAMPLE_LEN;
            m_lvl[v] = 1'b0;
        end
        m_div = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " rd_en"}, rom_rd_en, 1'b0);
        chk({tag, " addr"}, rom_addr, '0);
        chk({tag, " out0"}, sample_out0, '0);
        chk({tag, " out1"}, sample_out1, '0);
        chk({tag, " out2"}, sample_out2, '0);
        chk({tag, " out3"}, sample_out3, '0);
        chk({tag, " out_valid"}, out_valid, 1'b0);
        chk({tag, " overrun"}, overrun, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sample_strobe = 1'b0;
        repeat (2) tick();
        chk_all_zero("reset");
        rst = 1'b0;
        model_reset();
    endtask

    // One accepted strobe and its full sweep; dup>0 re-strobes at that cycle of the sweep.
    task automatic sweep(input logic signed [W-1:0] i0, input logic signed [W-1:0] i1,
                         input logic signed [W-1:0] i2, input logic signed [W-1:0] i3,
                         input int gap, input int dup);
        logic signed [W-1:0] in_v  [4];
        logic                exp_en [4];
        logic [AW-1:0]       exp_a  [4];
        logic signed [W-1:0] exp_o  [4];
        bit                  rs [4];
        bit                  adv;
        bit                  nl;
        in_v[0] = i0; in_v[1] = i1; in_v[2] = i2; in_v[3] = i3;
        for (int v = 0; v < 4; v++) begin
            if (in_v[v] >= HI)     nl = 1'b1;
            else if (in_v[v] < LO) nl = 1'b0;
            else                   nl = m_lvl[v];
            rs[v] = nl && !m_lvl[v] && (RETRIG || m_pos[v] >= SAMPLE_LEN);
            m_lvl[v] = nl;
            if (rs[v]) m_pos[v] = 0;
        end
        adv   = (m_div == RATE_DIV - 1);
        m_div = (m_div + 1) % RATE_DIV;
        for (int v = 0; v < 4; v++) begin
            exp_en[v] = (m_pos[v] < SAMPLE_LEN);
            exp_a[v]  = exp_en[v] ? AW'(v * SLOT_LEN + m_pos[v]) : '0;
            exp_o[v]  = exp_en[v] ? rom_word(int'(exp_a[v])) : '0;
            if (adv && !rs[v] && m_pos[v] < SAMPLE_LEN) m_pos[v]++;
        end
        sample_in0 = i0; sample_in1 = i1; sample_in2 = i2; sample_in3 = i3;
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (k <= 4) begin
                chk($sformatf("rd_en v%0d", k - 1), rom_rd_en, exp_en[k - 1]);
                chk($sformatf("addr v%0d", k - 1), rom_addr, exp_a[k - 1]);
            end
            if (k == 6) begin
                chk("out_valid pulse", out_valid, 1'b1);
                chk("out0", sample_out0, exp_o[0]);
                chk("out1", sample_out1, exp_o[1]);
                chk("out2", sample_out2, exp_o[2]);
                chk("out3", sample_out3, exp_o[3]);
            end else begin
                chk($sformatf("out_valid idle k%0d", k), out_valid, 1'b0);
            end
            if (k == dup) sample_strobe = 1'b1;
            if (k < 6) begin
                tick();
                sample_strobe = 1'b0;
            end
        end
        repeat (gap) tick();
    endtask

    logic signed [W-1:0] tbl [8];

    initial begin
        tbl = '{16'sd0, 16'sd1999, 16'sd2000, 16'sd2500, 16'sd3999, 16'sd4000, -16'sd4000, 16'sd32767};
        rst = 1'b1;
        sample_strobe = 1'b0;
        sample_in0 = '0; sample_in1 = '0; sample_in2 = '0; sample_in3 = '0;
        rom_rdata = '0;
        model_reset();
        do_reset();

        // Silence: no reads, zero outputs, one pulse per strobe
        for (int n = 0; n < 10; n++) sweep(16'sd0, 16'sd0, 16'sd0, 16'sd0, 1, 0);

        // Voice 1 start and advance cadence
        sweep(16'sd0, 16'sd4000, 16'sd0, 16'sd0, 0, 0);
        for (int n = 0; n < 3; n++) sweep(16'sd0, 16'sd4000, 16'sd0, 16'sd0, 2, 0);

        // Voice 0 hysteresis: 3000 no start, 4000 start, dip to 2500 and back no edge
        sweep(16'sd3000, 16'sd4000, 16'sd0, 16'sd0, 0, 0);
        sweep(16'sd4000, 16'sd4000, 16'sd0, 16'sd0, 0, 0);
        sweep(16'sd2500, 16'sd4000, 16'sd0, 16'sd0, 0, 0);
        sweep(16'sd4000, 16'sd4000, 16'sd0, 16'sd0, 0, 0);

        // Randomized trigger voltages around the thresholds
        for (int n = 0; n < 60; n++) begin
            sweep(tbl[$urandom_range(7)], tbl[$urandom_range(7)], tbl[$urandom_range(7)],
                  tbl[$urandom_range(7)], $urandom_range(2), 0);
        end

        // Strobe during a sweep: ignored, overrun sticky
        sweep(16'sd0, 16'sd0, 16'sd0, 16'sd0, 0, 3);
        chk("overrun set", overrun, 1'b1);
        sweep(16'sd0, 16'sd0, 16'sd0, 16'sd0, 1, 0);
        sweep(16'sd0, 16'sd0, 16'sd0, 16'sd0, 1, 0);
        chk("overrun sticky", overrun, 1'b1);

        // Voice 2 plays to completion with gate held high, then falls silent
        do_reset();
        for (int n = 0; n < 3370; n++) sweep(16'sd0, 16'sd0, 16'sd4000, 16'sd0, 0, 0);

        // Voice 0 to about position 500, then a fresh trigger edge
        sweep(16'sd4000, 16'sd0, 16'sd0, 16'sd0, 0, 0);
        for (int n = 0; n < 1000; n++) sweep(16'sd4000, 16'sd0, 16'sd0, 16'sd0, 0, 0);
        sweep(16'sd0, 16'sd0, 16'sd0, 16'sd0, 0, 0);
        sweep(16'sd4000, 16'sd0, 16'sd0, 16'sd0, 0, 0);
        sweep(16'sd4000, 16'sd0, 16'sd0, 16'sd0, 0, 0);
        sweep(16'sd4000, 16'sd0, 16'sd0, 16'sd0, 0, 0);

        // Reset while in READ2 aborts the sweep
        sample_in0 = 16'sd4000;
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk_all_zero("mid-sweep reset");
        rst = 1'b0;
        model_reset();
        for (int n = 0; n < 8; n++) begin
            tick();
            chk("no out_valid after abort", out_valid, 1'b0);
        end
        sweep(16'sd4000, 16'sd0, 16'sd0, 16'sd0, 0, 0);
        sweep(16'sd4000, 16'sd0, 16'sd0, 16'sd0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
